data_fetch_unit: RTL
====================

// Module: data_fetch_unit
// PURPOSE
//  Memory-side fetch/store engine feeding the CU_PE_Wrapper.
//  - On ADDR_START: reads 1, 2 or 4 words from data memory and presents them on the PE lanes (DATAIN).
//  - On WRADDR_START: writes the selected PE results (DATAOUT) back to memory.
//  - Handshakes to the CU via FETCH_DONE / STORE_DONE.
// PARAMETERS
//  DATA_W   32  lane and memory word width
//  ADDR_W   6   memory address width; >= 6, {ADDRESS,lane} zero-extended
// PORTS
//  CLK           in   1         clock, rising edge
//  RST           in   1         asynchronous reset, active-high
//  ADDR_START    in   1         1-cycle pulse: begin fetch at row ADDRESS
//  ADDR_RST      in   1         synchronous abort / clear
//  ADDRESS       in   4         row index; word address = {ADDRESS,lane[1:0]}
//  PE_SEL        in   2         lane select, single-lane mode
//  PE_SEL_2x2    in   1         2-lane mode: lanes {PE_SEL[1],0},{PE_SEL[1],1}
//  PE_SEL_4      in   1         4-lane mode: lanes 0..3; priority over PE_SEL_2x2
//  WRADDR_START  in   1         1-cycle pulse: begin store of DATAOUT at row ADDRESS
//  DATAOUT       in   4xDATA_W  PE results (lane-packed)
//  DATAIN        out  4xDATA_W  fetched operands to PEs
//  FETCH_DONE    out  1         1-cycle pulse, DATAIN valid
//  STORE_DONE    out  1         1-cycle pulse, all writes issued
//  BUSY          out  1         high in any non-IDLE state
//  MEM_ADDR      out  ADDR_W    memory word address
//  MEM_RDEN      out  1         read enable; MEM_RDATA valid one cycle later
//  MEM_RDATA     in   DATA_W    read data, fixed 1-cycle latency
//  MEM_WREN      out  1         write enable
//  MEM_WDATA     out  DATA_W    write data
// BEHAVIOUR
//  - Reset: all outputs 0, DATAIN lanes 0, FSM IDLE. All outputs registered.
//  - N = 4 if PE_SEL_4; 2 if PE_SEL_2x2; else 1.
//  - Mode, ADDRESS and DATAOUT are sampled with the start pulse and held for the whole transfer.
//  - FSM states: IDLE, READ, DRAIN, WRITE.
//  - IDLE->READ on ADDR_START. IDLE->WRITE on WRADDR_START.
//  - Both starts high in the same cycle: fetch wins, store is dropped.
//  - Start pulses while BUSY are ignored, with no queueing.
//  - Fetch, sampled at edge E0:
//    - MEM_RDEN=1 for N cycles, addresses ascending by lane, from E0 to E(N-1).
//    - Each MEM_RDATA is captured into its lane one edge after issue.
//    - At E(N+1): last lane written, FETCH_DONE=1 for one cycle, state returns to IDLE.
//    - Latency from start edge to FETCH_DONE: N+1 cycles (4-lane: 5).
//    - Selected lanes are overwritten. Unselected lanes are cleared to 0 at E0.
//    - DATAIN holds until the next fetch, ADDR_RST or RST.
//  - Store, sampled at E0:
//    - DATAOUT selected lanes are snapshotted.
//    - MEM_WREN=1 with MEM_ADDR/MEM_WDATA per lane for N cycles, E0..E(N-1).
//    - STORE_DONE=1 for one cycle from E_N, state returns to IDLE.
//    - MEM_RDEN and MEM_WREN are never high together.
//  - ADDR_RST (highest synchronous priority, any state):
//    - Next edge: IDLE, DATAIN=0, all strobes 0.
//    - No done pulse; any in-flight read data is discarded.
//    - A start pulse in the same cycle is ignored.
//  - RST mid-transfer: immediate return to reset values; no done pulse.
//  - Lane-2x2 with PE_SEL[1]=1: addresses {ADDRESS,2'b10},{ADDRESS,2'b11}.
// CONFIGURATION
//  - Macro DFU_XFER_CNT_EN.
//  - Defined: adds output XFER_CNT[15:0].
//    - +1 per word read-captured or write-issued.
//    - Saturates at 16'hFFFF.
//    - Cleared by RST only, not by ADDR_RST.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - 2x2 fetch, PE_SEL=2'b00, ADDRESS=5, mem[20]=23, mem[21]=63
//    -> RDEN addr 20,21; FETCH_DONE 3 cycles after start; DATAIN={0,0,63,23}.
//  - 4-lane fetch, ADDRESS=3, mem[12..15]=1,2,3,4
//    -> FETCH_DONE 5 cycles after start; DATAIN={4,3,2,1}; BUSY low next cycle.
//  - Store, PE_SEL_2x2, PE_SEL=2'b10, ADDRESS=1, DATAOUT lanes2/3=56/78
//    -> WREN addr 6=56, 7=78; STORE_DONE 2 cycles after start.
//  - ADDR_START+WRADDR_START same cycle
//    -> only reads issued; no STORE_DONE. Second start while BUSY -> ignored.
//  - ADDR_RST on 2nd read cycle of 4-lane fetch
//    -> IDLE next edge, DATAIN=0, no FETCH_DONE; RST mid-store likewise.
//  - With DFU_XFER_CNT_EN: fetch4 + store2 -> XFER_CNT=6; ADDR_RST leaves it at 6.

Source files
------------

// File: rtl/data_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_fetch_unit
// Description : Memory-side fetch/store engine for the CU_PE_Wrapper.
//               ADDR_START fetches 1, 2 or 4 words into the PE lanes (DATAIN).
//               WRADDR_START writes the selected PE results (DATAOUT) back to
//               memory. FETCH_DONE / STORE_DONE pulse when a transfer finishes.
// Ports       : CLK, RST (async, active-high), ADDR_RST (sync abort/clear)
//               ADDR_START / WRADDR_START, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4
//               DATAOUT (lane-packed in), DATAIN (lane-packed out, lane 0 LSB)
//               FETCH_DONE, STORE_DONE, BUSY
//               MEM_ADDR, MEM_RDEN, MEM_RDATA (1-cycle latency), MEM_WREN,
//               MEM_WDATA
//               XFER_CNT (only when DFU_XFER_CNT_EN is defined)
// Config      : DFU_XFER_CNT_EN - adds saturating 16-bit word transfer counter
// Revision    : 1.0 - initial release
// ============================================================================
module data_fetch_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ADDR_START,
  input  logic                ADDR_RST,
  input  logic [3:0]          ADDRESS,
  input  logic [1:0]          PE_SEL,
  input  logic                PE_SEL_2x2,
  input  logic                PE_SEL_4,
  input  logic                WRADDR_START,
  input  logic [4*DATA_W-1:0] DATAOUT,
  output logic [4*DATA_W-1:0] DATAIN,
  output logic                FETCH_DONE,
  output logic                STORE_DONE,
  output logic                BUSY,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic                MEM_RDEN,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  output logic                MEM_WREN,
  output logic [DATA_W-1:0]   MEM_WDATA
`ifdef DFU_XFER_CNT_EN
  ,
  output logic [15:0]         XFER_CNT
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, WRITE = 2'd3} state_t;

  state_t                   state, state_n;
  logic [1:0]               cnt, cnt_n;       // index of word currently issued
  logic [1:0]               base, base_n;     // first selected lane
  logic [1:0]               last, last_n;     // N-1
  logic [3:0]               row, row_n;
  logic [3:0][DATA_W-1:0]   snap, snap_n;     // DATAOUT snapshot for stores
  logic [3:0][DATA_W-1:0]   din, din_n;
  logic [ADDR_W-1:0]        maddr, maddr_n;
  logic                     rden, rden_n, wren, wren_n;
  logic [DATA_W-1:0]        wdat, wdat_n;
  logic                     fdone, fdone_n, sdone, sdone_n, busy, busy_n;
  // Read-return pipeline: MEM_RDATA for the word issued last cycle is
  // present this cycle, so its lane tag is delayed by one stage.
  logic                     pend, pend_n, plast, plast_n;
  logic [1:0]               plane, plane_n;

  logic [3:0][DATA_W-1:0]   dout_lanes;
  logic [1:0]               start_base, start_last, next_lane;

  assign dout_lanes = DATAOUT;
  assign start_last = PE_SEL_4 ? 2'd3 : (PE_SEL_2x2 ? 2'd1 : 2'd0);
  assign start_base = PE_SEL_4 ? 2'd0 : (PE_SEL_2x2 ? {PE_SEL[1], 1'b0} : PE_SEL);
  assign next_lane  = 2'(base + cnt + 2'd1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    base_n  = base;
    last_n  = last;
    row_n   = row;
    snap_n  = snap;
    din_n   = din;
    maddr_n = maddr;
    rden_n  = 1'b0;
    wren_n  = 1'b0;
    wdat_n  = wdat;
    fdone_n = 1'b0;
    sdone_n = 1'b0;
    pend_n  = 1'b0;
    plane_n = plane;
    plast_n = plast;

    if (pend) begin
      din_n[plane] = MEM_RDATA;
      if (plast) begin
        fdone_n = 1'b1;
        state_n = IDLE;
      end
    end

    case (state)
      IDLE: begin
        if (ADDR_START) begin
          state_n = READ;
          cnt_n   = 2'd0;
          base_n  = start_base;
          last_n  = start_last;
          row_n   = ADDRESS;
          rden_n  = 1'b1;
          maddr_n = ADDR_W'({ADDRESS, start_base});
          for (int i = 0; i < 4; i++) begin
            if (i < int'(start_base) || i > int'(start_base) + int'(start_last))
              din_n[i] = '0;
          end
        end else if (WRADDR_START) begin
          state_n = WRITE;
          cnt_n   = 2'd0;
          base_n  = start_base;
          last_n  = start_last;
          row_n   = ADDRESS;
          snap_n  = dout_lanes;
          wren_n  = 1'b1;
          maddr_n = ADDR_W'({ADDRESS, start_base});
          wdat_n  = dout_lanes[start_base];
        end
      end
      READ: begin
        pend_n  = 1'b1;
        plane_n = 2'(base + cnt);
        plast_n = (cnt == last);
        if (cnt == last) begin
          state_n = DRAIN;
        end else begin
          cnt_n   = cnt + 2'd1;
          rden_n  = 1'b1;
          maddr_n = ADDR_W'({row, next_lane});
        end
      end
      WRITE: begin
        if (cnt == last) begin
          state_n = IDLE;
          sdone_n = 1'b1;
        end else begin
          cnt_n   = cnt + 2'd1;
          wren_n  = 1'b1;
          maddr_n = ADDR_W'({row, next_lane});
          wdat_n  = snap[next_lane];
        end
      end
      default: ;  // DRAIN: waits for the final capture above
    endcase

    // Synchronous abort overrides everything, including in-flight captures.
    if (ADDR_RST) begin
      state_n = IDLE;
      din_n   = '0;
      rden_n  = 1'b0;
      wren_n  = 1'b0;
      fdone_n = 1'b0;
      sdone_n = 1'b0;
      pend_n  = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      last  <= '0;
      row   <= '0;
      snap  <= '0;
      din   <= '0;
      maddr <= '0;
      rden  <= 1'b0;
      wren  <= 1'b0;
      wdat  <= '0;
      fdone <= 1'b0;
      sdone <= 1'b0;
      busy  <= 1'b0;
      pend  <= 1'b0;
      plane <= '0;
      plast <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      base  <= base_n;
      last  <= last_n;
      row   <= row_n;
      snap  <= snap_n;
      din   <= din_n;
      maddr <= maddr_n;
      rden  <= rden_n;
      wren  <= wren_n;
      wdat  <= wdat_n;
      fdone <= fdone_n;
      sdone <= sdone_n;
      busy  <= busy_n;
      pend  <= pend_n;
      plane <= plane_n;
      plast <= plast_n;
    end
  end

  assign DATAIN     = din;
  assign FETCH_DONE = fdone;
  assign STORE_DONE = sdone;
  assign BUSY       = busy;
  assign MEM_ADDR   = maddr;
  assign MEM_RDEN   = rden;
  assign MEM_WREN   = wren;
  assign MEM_WDATA  = wdat;

`ifdef DFU_XFER_CNT_EN
  // One count per word captured from memory or per write issued.
  logic [15:0] xcnt;
  logic        xinc;

  assign xinc = (pend & ~ADDR_RST) | wren_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      xcnt <= '0;
    else if (xinc && xcnt != 16'hFFFF)
      xcnt <= xcnt + 16'd1;
  end

  assign XFER_CNT = xcnt;
`endif

endmodule
`default_nettype wire
